// File: rtl/inst_encoder_loader.sv
// inst_encoder_loader
//   Loads a test program into instruction memory before the core leaves
//   reset. Each instruction arrives as symbolic fields over a valid/ready
//   handshake. The loader encodes it as a 32-bit MIPS word and writes it to
//   the next consecutive word address.
//   Supported kinds: add, j, addi, bgtz, lw, sw.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   If defined, checksum is the running XOR of every word written in the
//   current session. If not defined, checksum is constant zero.
//
// Parameters
//   ADDR_W     instruction-memory word-address width (capacity 2**ADDR_W words)
//   BASE_ADDR  first word address written after start
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   start             begins a load session (honoured only in IDLE)
//   in_valid/in_ready handshake for the instruction fields
//   in_last           marks the final instruction of the program
//   kind              0 add, 1 j, 2 addi, 3 bgtz, 4 lw, 5 sw (6, 7 illegal)
//   rs, rt, rd, imm, target   instruction fields
//   mem_we, mem_addr, mem_wdata   instruction-memory write port
//   busy              session active (LOAD or WRITE)
//   done              one-cycle pulse when a session ends
//   full              sticky: session ended because the top word was written
//   err               sticky: an illegal kind was offered
//   count             words written this session
//   checksum          running XOR of written words (see macro above)
//
// States
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_LOAD  | accepting the next instruction
//   S_WRITE | one-cycle memory write of the encoded word
//   S_DONE  | one-cycle done pulse, then back to idle
module inst_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        kind,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   count,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_TOP  = '1;

  state_t      state, state_next;
  logic [31:0] enc_word;
  logic        enc_legal;
  logic        last_q;

  // Encoder. Fields that a format does not use are forced to zero.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (kind)
      3'd0:    enc_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
      3'd1:    enc_word = {6'b000010, target};
      3'd2:    enc_word = {6'b001000, rs, rt, imm};
      3'd3:    enc_word = {6'b000111, rs, 5'd0, imm};
      3'd4:    enc_word = {6'b100011, rs, rt, imm};
      3'd5:    enc_word = {6'b101011, rs, rt, imm};
      default: enc_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          if (enc_legal)    state_next = S_WRITE;
          // An illegal kind is consumed. If it was the last one, the session still ends.
          else if (in_last) state_next = S_DONE;
        end
      end
      S_WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
        if (last_q || (mem_addr == ADDR_TOP)) state_next = S_DONE;
        else                                  state_next = S_LOAD;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= ADDR_BASE;
      mem_wdata <= '0;
      count     <= '0;
      full      <= 1'b0;
      err       <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mem_addr <= ADDR_BASE;
            count    <= '0;
            full     <= 1'b0;
            err      <= 1'b0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (enc_legal) begin
              mem_wdata <= enc_word;
              last_q    <= in_last;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          count <= count + (ADDR_W+1)'(1);
          // The address never wraps. At the top, it holds and the session ends as full.
          if (mem_addr == ADDR_TOP) full     <= 1'b1;
          else if (!last_q)         mem_addr <= mem_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)                           checksum <= '0;
    else if (state == S_IDLE && start) checksum <= '0;
    else if (state == S_WRITE)         checksum <= checksum ^ mem_wdata;
  end
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_inst_encoder_loader.sv
// tb_inst_encoder_loader
//   Directed bench for inst_encoder_loader. Instance a uses the default
//   address width. Instance b uses ADDR_W=2 so that the full/stop behaviour
//   can be reached.
module tb_inst_encoder_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b, valid_a, valid_b, in_last;
  logic [2:0]  kind;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;

  logic        ready_a, we_a, busy_a, done_a, full_a, err_a;
  logic [7:0]  addr_a;
  logic [31:0] wdata_a, csum_a;
  logic [8:0]  count_a;

  logic        ready_b, we_b, busy_b, done_b, full_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b, csum_b;
  logic [2:0]  count_b;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  wa_q[$];
  logic [31:0] wd_q[$];
  logic [1:0]  wb_q[$];
  int          done_cnt_a = 0, done_cnt_b = 0, ready_bad = 0;

  always #5 clk = ~clk;

  inst_encoder_loader dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(valid_a), .in_ready(ready_a),
    .in_last(in_last), .kind(kind), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a), .busy(busy_a), .done(done_a),
    .full(full_a), .err(err_a), .count(count_a), .checksum(csum_a)
  );

  inst_encoder_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(valid_b), .in_ready(ready_b),
    .in_last(in_last), .kind(kind), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b), .busy(busy_b), .done(done_b),
    .full(full_b), .err(err_b), .count(count_b), .checksum(csum_b)
  );

  always @(negedge clk) begin
    if (we_a) begin
      wa_q.push_back(addr_a);
      wd_q.push_back(wdata_a);
      if (ready_a) ready_bad++;
    end
    if (we_b) wb_q.push_back(addr_b);
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wa_q.delete(); wd_q.delete(); wb_q.delete();
    done_cnt_a = 0; done_cnt_b = 0; ready_bad = 0;
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic offer(input bit sel, input logic [2:0] k, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [15:0] im, input logic [25:0] tg,
                       input bit last, input int bound, output bit acc);
    int n;
    kind = k; rs = s; rt = t; rd = d; imm = im; target = tg; in_last = last;
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    acc = 1'b0;
    n = 0;
    while (n < bound) begin
      @(negedge clk);
      if ((sel ? ready_b : ready_a) === 1'b1) begin
        acc = 1'b1;
        break;
      end
      n++;
    end
    @(posedge clk); #1;
    valid_a = 1'b0; valid_b = 1'b0; in_last = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    bit acc;
    logic [31:0] exp_csum;
    rst = 1'b1; start_a = 0; start_b = 0; valid_a = 0; valid_b = 0; in_last = 0;
    kind = 0; rs = 0; rt = 0; rd = 0; imm = 0; target = 0;
    repeat (2) @(posedge clk);
    #1;

    chk("reset_outputs", {27'd0, ready_a, we_a, busy_a, done_a, full_a}, 32'h0);
    chk("reset_err_addr", {23'd0, err_a, addr_a}, 32'h0);
    chk("reset_data_count", wdata_a | {23'd0, count_a} | csum_a, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: single add
    clear_log();
    pulse_start(0);
    chk("t1_busy_after_start", {31'd0, busy_a}, 32'd1);
    offer(0, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1, 20, acc);
    chk("t1_accept", {31'd0, acc}, 32'd1);
    settle();
    chk("t1_nwrites", wa_q.size(), 32'd1);
    chk("t1_addr", {24'd0, wa_q[0]}, 32'd0);
    chk("t1_data", wd_q[0], 32'h00221820);
    chk("t1_done_pulses", done_cnt_a, 32'd1);
    chk("t1_count", {23'd0, count_a}, 32'd1);
    chk("t1_idle", {30'd0, busy_a, ready_a}, 32'd0);

    // 2: addi, lw, sw; a start pulse mid-session must be ignored
    clear_log();
    pulse_start(0);
    offer(0, 3'd2, 5'd0, 5'd5, 5'd0, 16'd7, 26'h0, 0, 20, acc);
    pulse_start(0);
    offer(0, 3'd4, 5'd29, 5'd8, 5'd0, 16'd4, 26'h0, 0, 20, acc);
    offer(0, 3'd5, 5'd29, 5'd9, 5'd0, 16'd8, 26'h0, 1, 20, acc);
    settle();
    chk("t2_nwrites", wa_q.size(), 32'd3);
    chk("t2_addr0", {24'd0, wa_q[0]}, 32'd0);
    chk("t2_addr1", {24'd0, wa_q[1]}, 32'd1);
    chk("t2_addr2", {24'd0, wa_q[2]}, 32'd2);
    chk("t2_data0", wd_q[0], 32'h20050007);
    chk("t2_data1", wd_q[1], 32'h8FA80004);
    chk("t2_data2", wd_q[2], 32'hAFA90008);
    chk("t2_count", {23'd0, count_a}, 32'd3);
`ifdef LOADER_CHECKSUM_EN
    exp_csum = 32'h20050007 ^ 32'h8FA80004 ^ 32'hAFA90008;
`else
    exp_csum = 32'h0;
`endif
    chk("t2_checksum", csum_a, exp_csum);

    // 3: j and bgtz with negative offset
    clear_log();
    pulse_start(0);
    offer(0, 3'd1, 5'd7, 5'd7, 5'd7, 16'h1234, 26'h10, 0, 20, acc);
    offer(0, 3'd3, 5'd4, 5'd9, 5'd3, 16'hFFFE, 26'h0, 1, 20, acc);
    settle();
    chk("t3_nwrites", wa_q.size(), 32'd2);
    chk("t3_data0", wd_q[0], 32'h08000010);
    chk("t3_data1", wd_q[1], 32'h1C80FFFE);
    chk("t3_addr1", {24'd0, wa_q[1]}, 32'd1);
    chk("t3_ready_in_write", ready_bad, 32'd0);

    // 4: illegal kind mid-stream
    clear_log();
    pulse_start(0);
    offer(0, 3'd2, 5'd1, 5'd1, 5'd0, 16'd1, 26'h0, 0, 20, acc);
    offer(0, 3'd6, 5'd3, 5'd3, 5'd3, 16'd3, 26'h3, 0, 20, acc);
    chk("t4_illegal_consumed", {31'd0, acc}, 32'd1);
    offer(0, 3'd4, 5'd2, 5'd3, 5'd0, 16'd0, 26'h0, 1, 20, acc);
    settle();
    chk("t4_err", {31'd0, err_a}, 32'd1);
    chk("t4_nwrites", wa_q.size(), 32'd2);
    chk("t4_addr1", {24'd0, wa_q[1]}, 32'd1);
    chk("t4_data1", wd_q[1], 32'h8C430000);
    chk("t4_count", {23'd0, count_a}, 32'd2);

    // 5: small memory fills up; fifth word is never accepted
    clear_log();
    pulse_start(1);
    for (int i = 0; i < 4; i++) begin
      offer(1, 3'd0, 5'd1, 5'd1, 5'd1, 16'd0, 26'h0, 0, 20, acc);
      chk("t5_accept", {31'd0, acc}, 32'd1);
    end
    offer(1, 3'd0, 5'd1, 5'd1, 5'd1, 16'd0, 26'h0, 0, 8, acc);
    chk("t5_fifth_rejected", {31'd0, acc}, 32'd0);
    chk("t5_nwrites", wb_q.size(), 32'd4);
    chk("t5_last_addr", {30'd0, wb_q[3]}, 32'd3);
    chk("t5_full", {31'd0, full_b}, 32'd1);
    chk("t5_done_pulses", done_cnt_b, 32'd1);
    chk("t5_count", {29'd0, count_b}, 32'd4);
    chk("t5_hold_addr", {30'd0, addr_b}, 32'd3);

    // 6: reset while writing
    clear_log();
    pulse_start(0);
    offer(0, 3'd2, 5'd1, 5'd2, 5'd0, 16'd9, 26'h0, 0, 20, acc);
    chk("t6_in_write", {31'd0, we_a}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_we_after_rst", {31'd0, we_a}, 32'd0);
    chk("t6_idle_after_rst", {30'd0, busy_a, ready_a}, 32'd0);
    chk("t6_count_after_rst", {23'd0, count_a}, 32'd0);
    chk("t6_csum_after_rst", csum_a, 32'd0);
    offer(0, 3'd2, 5'd1, 5'd2, 5'd0, 16'd9, 26'h0, 0, 5, acc);
    chk("t6_no_accept_in_idle", {31'd0, acc}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
